// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Load/store stage that sits after the ALU. It takes the effective address and
// the rt value, runs a single transaction on a word-wide data bus with
// waitrequest flow control, and returns an extended load result. Byte order is
// big-endian: lane 0 is bits 31:24 and is enabled by mem_byteenable[3].
// Misaligned half/word accesses complete without touching the bus and report
// AddrError (when CHECK_ALIGN=1).
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   Start               one-cycle request pulse, only honoured in IDLE
//   IsWrite             1 = store, 0 = load
//   Size                00 byte, 01 half, 10 word, 11 treated as word
//   SignExt             loads only: 1 = sign-extend, 0 = zero-extend
//   Address             effective address from the ALU
//   StoreData           rt value (byte/half data in the low bits)
//   LoadData            extended load result, valid while Done=1
//   Done                one-cycle completion pulse
//   Busy                high in ACCESS and DONE (pipeline stall)
//   AddrError           valid with Done: misaligned, no bus access made
//   mem_address         word address, low two bits always zero
//   mem_read/mem_write  bus request strobes
//   mem_byteenable      bit3 = lane 0 (MSB) ... bit0 = lane 3
//   mem_writedata       store data replicated onto the lanes
//   mem_readdata        read data, valid when mem_read=1 and waitrequest=0
//   mem_waitrequest     slave stall; all request signals are held meanwhile
// -----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int ADDR_W      = 32,
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Start,
    input  logic              IsWrite,
    input  logic [1:0]        Size,
    input  logic              SignExt,
    input  logic [31:0]       Address,
    input  logic [31:0]       StoreData,
    output logic [31:0]       LoadData,
    output logic              Done,
    output logic              Busy,
    output logic              AddrError,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [3:0]        mem_byteenable,
    output logic [31:0]       mem_writedata,
    input  logic [31:0]       mem_readdata,
    input  logic              mem_waitrequest
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t      state_reg;
    logic [1:0]  size_reg;
    logic        sign_ext_reg;
    logic [1:0]  offset_reg;

    // ---------------------------------------------------------------------
    // Request decode from the raw inputs (used only when accepting Start)
    // ---------------------------------------------------------------------
    logic [1:0]        size_next;
    logic              misaligned_next;
    logic [3:0]        byteenable_next;
    logic [31:0]       writedata_next;
    logic [31:0]       word_addr32_next;
    logic [ADDR_W-1:0] address_next;

    // Reserved size code behaves exactly like a word access.
    assign size_next = (Size == 2'b11) ? SZ_WORD : Size;

    always_comb begin
        misaligned_next = 1'b0;
        if (CHECK_ALIGN) begin
            if (size_next == SZ_HALF && Address[0])
                misaligned_next = 1'b1;
            else if (size_next == SZ_WORD && Address[1:0] != 2'b00)
                misaligned_next = 1'b1;
        end
    end

    assign word_addr32_next = {Address[31:2], 2'b00};
    assign address_next     = word_addr32_next[ADDR_W-1:0];

    // Per-lane byte enable and write data. Lane gi occupies bits
    // [31-8*gi -: 8] and is enabled by byteenable bit 3-gi.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_store_lane
            always_comb begin
                case (size_next)
                    SZ_BYTE: begin
                        byteenable_next[3-gi]          = (Address[1:0] == 2'(gi));
                        writedata_next[31-8*gi -: 8]   = StoreData[7:0];
                    end
                    SZ_HALF: begin
                        // Half occupies lanes {0,1} or {2,3}; in either pair
                        // the even lane carries the upper byte.
                        byteenable_next[3-gi]          = (Address[1] == 1'(gi / 2));
                        writedata_next[31-8*gi -: 8]   = ((gi % 2) == 0) ? StoreData[15:8]
                                                                         : StoreData[7:0];
                    end
                    default: begin
                        byteenable_next[3-gi]          = 1'b1;
                        writedata_next[31-8*gi -: 8]   = StoreData[31-8*gi -: 8];
                    end
                endcase
            end
        end
    endgenerate

    // ---------------------------------------------------------------------
    // Load extraction from the bus, using the latched request attributes
    // ---------------------------------------------------------------------
    logic [7:0]  rd_lane [4];
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_ext;

    generate
        for (gi = 0; gi < 4; gi++) begin : g_load_lane
            assign rd_lane[gi] = mem_readdata[31-8*gi -: 8];
        end
    endgenerate

    assign load_byte = rd_lane[offset_reg];
    assign load_half = offset_reg[1] ? mem_readdata[15:0] : mem_readdata[31:16];

    always_comb begin
        case (size_reg)
            SZ_BYTE: load_ext = {{24{sign_ext_reg & load_byte[7]}}, load_byte};
            SZ_HALF: load_ext = {{16{sign_ext_reg & load_half[15]}}, load_half};
            default: load_ext = mem_readdata;
        endcase
    end

    // ---------------------------------------------------------------------
    // Control FSM; every output is a register so waitrequest never reaches
    // mem_read/mem_write combinationally.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            size_reg       <= SZ_BYTE;
            sign_ext_reg   <= 1'b0;
            offset_reg     <= 2'b00;
            LoadData       <= '0;
            Done           <= 1'b0;
            Busy           <= 1'b0;
            AddrError      <= 1'b0;
            mem_address    <= '0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_byteenable <= '0;
            mem_writedata  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    Done      <= 1'b0;
                    AddrError <= 1'b0;
                    if (Start) begin
                        size_reg     <= size_next;
                        sign_ext_reg <= SignExt;
                        offset_reg   <= Address[1:0];
                        Busy         <= 1'b1;
                        if (misaligned_next) begin
                            // Trap: skip the bus and complete next cycle.
                            state_reg <= ST_DONE;
                            Done      <= 1'b1;
                            AddrError <= 1'b1;
                            LoadData  <= '0;
                        end else begin
                            state_reg      <= ST_ACCESS;
                            mem_read       <= ~IsWrite;
                            mem_write      <= IsWrite;
                            mem_address    <= address_next;
                            mem_byteenable <= byteenable_next;
                            mem_writedata  <= writedata_next;
                        end
                    end
                end

                ST_ACCESS: begin
                    // Request signals simply keep their values while stalled.
                    if (!mem_waitrequest) begin
                        state_reg <= ST_DONE;
                        Done      <= 1'b1;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        LoadData  <= mem_read ? load_ext : '0;
                    end
                end

                ST_DONE: begin
                    state_reg <= ST_IDLE;
                    Done      <= 1'b0;
                    Busy      <= 1'b0;
                    AddrError <= 1'b0;
                end

                default: begin
                    state_reg <= ST_IDLE;
                    Done      <= 1'b0;
                    Busy      <= 1'b0;
                    AddrError <= 1'b0;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
//
// Directed, table-driven bench for mem_access_unit. One instance uses
// CHECK_ALIGN=1 (main DUT), a second one with CHECK_ALIGN=0 shares all inputs
// and is observed for the unaligned-access-allowed case.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

    logic        clk;
    logic        rst_n;
    logic        Start;
    logic        IsWrite;
    logic [1:0]  Size;
    logic        SignExt;
    logic [31:0] Address;
    logic [31:0] StoreData;
    logic [31:0] mem_readdata;
    logic        mem_waitrequest;

    logic [31:0] LoadData,  u1_LoadData;
    logic        Done,      u1_Done;
    logic        Busy,      u1_Busy;
    logic        AddrError, u1_AddrError;
    logic [31:0] mem_address,    u1_mem_address;
    logic        mem_read,       u1_mem_read;
    logic        mem_write,      u1_mem_write;
    logic [3:0]  mem_byteenable, u1_mem_byteenable;
    logic [31:0] mem_writedata,  u1_mem_writedata;

    int checks   = 0;
    int failures = 0;

    mem_access_unit #(.ADDR_W(32), .CHECK_ALIGN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .Start(Start), .IsWrite(IsWrite), .Size(Size),
        .SignExt(SignExt), .Address(Address), .StoreData(StoreData),
        .LoadData(LoadData), .Done(Done), .Busy(Busy), .AddrError(AddrError),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata),
        .mem_readdata(mem_readdata), .mem_waitrequest(mem_waitrequest)
    );

    mem_access_unit #(.ADDR_W(32), .CHECK_ALIGN(1'b0)) dut_noalign (
        .clk(clk), .rst_n(rst_n), .Start(Start), .IsWrite(IsWrite), .Size(Size),
        .SignExt(SignExt), .Address(Address), .StoreData(StoreData),
        .LoadData(u1_LoadData), .Done(u1_Done), .Busy(u1_Busy), .AddrError(u1_AddrError),
        .mem_address(u1_mem_address), .mem_read(u1_mem_read), .mem_write(u1_mem_write),
        .mem_byteenable(u1_mem_byteenable), .mem_writedata(u1_mem_writedata),
        .mem_readdata(mem_readdata), .mem_waitrequest(mem_waitrequest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        is_write;
        logic [1:0]  size;
        logic        sign_ext;
        logic [31:0] addr;
        logic [31:0] store_data;
        logic [31:0] read_data;
        int          waits;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        logic [31:0] exp_load;
        logic        exp_aerr;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Issue one request and follow it to Done, checking bus fields each cycle.
    task automatic run_txn(input vec_t v, input int idx);
        int          cyc;
        int          req_cyc;
        int          done_cyc;
        logic        bad_field;
        logic        busy_bad;
        logic [31:0] ld;
        logic        ae;
        int          exp_lat;
        int          exp_req;
        cyc = 0; req_cyc = 0; done_cyc = -1; bad_field = 0; busy_bad = 0;
        ld = '0; ae = 1'b0;
        @(negedge clk);
        IsWrite = v.is_write; Size = v.size; SignExt = v.sign_ext;
        Address = v.addr; StoreData = v.store_data; mem_readdata = v.read_data;
        mem_waitrequest = 1'b0; Start = 1'b1;
        while (done_cyc < 0 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            Start = 1'b0;
            mem_waitrequest = (cyc <= v.waits);
            if (!Busy) busy_bad = 1'b1;
            if (mem_read || mem_write) begin
                req_cyc++;
                if (mem_read !== ~v.is_write || mem_write !== v.is_write ||
                    mem_address !== v.exp_addr || mem_byteenable !== v.exp_be ||
                    mem_writedata !== v.exp_wd)
                    bad_field = 1'b1;
            end
            if (Done) begin
                done_cyc = cyc; ld = LoadData; ae = AddrError;
            end
        end
        mem_waitrequest = 1'b0;
        exp_lat = v.exp_aerr ? 1 : 2 + v.waits;
        exp_req = v.exp_aerr ? 0 : 1 + v.waits;
        chk($sformatf("v%0d_latency", idx), 32'(done_cyc), 32'(exp_lat));
        chk($sformatf("v%0d_req_cycles", idx), 32'(req_cyc), 32'(exp_req));
        chk($sformatf("v%0d_bus_fields_bad", idx), {31'd0, bad_field}, 32'd0);
        chk($sformatf("v%0d_busy_drop", idx), {31'd0, busy_bad}, 32'd0);
        chk($sformatf("v%0d_addr_error", idx), {31'd0, ae}, {31'd0, v.exp_aerr});
        if (!v.is_write || v.exp_aerr)
            chk($sformatf("v%0d_load_data", idx), ld, v.exp_load);
        @(negedge clk);
        chk($sformatf("v%0d_idle_after", idx), {30'd0, Done, Busy}, 32'd0);
        $display("txn %0d: wr=%0b size=%0d addr=0x%08h latency=%0d load=0x%08h aerr=%0b",
                 idx, v.is_write, v.size, v.addr, done_cyc, ld, ae);
    endtask

    vec_t vecs[13];

    initial begin
        // {wr, size, sext, addr, sdata, rdata, waits, exp_addr, exp_be, exp_wd, exp_load, exp_aerr}
        vecs[0]  = '{1'b1, 2'b10, 1'b0, 32'h0000_1004, 32'hDEAD_BEEF, 32'h0, 0, 32'h0000_1004, 4'b1111, 32'hDEAD_BEEF, 32'h0, 1'b0};
        vecs[1]  = '{1'b0, 2'b00, 1'b1, 32'h0000_2001, 32'h0, 32'h8899_AABB, 0, 32'h0000_2000, 4'b0100, 32'h0, 32'hFFFF_FF99, 1'b0};
        vecs[2]  = '{1'b0, 2'b00, 1'b0, 32'h0000_2001, 32'h0, 32'h8899_AABB, 0, 32'h0000_2000, 4'b0100, 32'h0, 32'h0000_0099, 1'b0};
        vecs[3]  = '{1'b0, 2'b00, 1'b1, 32'h0000_2003, 32'h0, 32'h8899_AABB, 0, 32'h0000_2000, 4'b0001, 32'h0, 32'hFFFF_FFBB, 1'b0};
        vecs[4]  = '{1'b0, 2'b00, 1'b1, 32'h0000_2000, 32'h0, 32'h8899_AABB, 1, 32'h0000_2000, 4'b1000, 32'h0, 32'hFFFF_FF88, 1'b0};
        vecs[5]  = '{1'b1, 2'b01, 1'b0, 32'h0000_3002, 32'h0000_1234, 32'h0, 3, 32'h0000_3000, 4'b0011, 32'h1234_1234, 32'h0, 1'b0};
        vecs[6]  = '{1'b0, 2'b01, 1'b1, 32'h0000_3000, 32'h0, 32'h8899_AABB, 0, 32'h0000_3000, 4'b1100, 32'h0, 32'hFFFF_8899, 1'b0};
        vecs[7]  = '{1'b0, 2'b01, 1'b0, 32'h0000_3002, 32'h0, 32'h8899_AABB, 0, 32'h0000_3000, 4'b0011, 32'h0, 32'h0000_AABB, 1'b0};
        vecs[8]  = '{1'b0, 2'b10, 1'b1, 32'h0000_4008, 32'h0, 32'h8899_AABB, 2, 32'h0000_4008, 4'b1111, 32'h0, 32'h8899_AABB, 1'b0};
        vecs[9]  = '{1'b1, 2'b00, 1'b0, 32'h0000_5002, 32'hFFFF_FF5A, 32'h0, 0, 32'h0000_5000, 4'b0010, 32'h5A5A_5A5A, 32'h0, 1'b0};
        vecs[10] = '{1'b0, 2'b11, 1'b1, 32'h0000_6000, 32'h0, 32'h1234_5678, 0, 32'h0000_6000, 4'b1111, 32'h0, 32'h1234_5678, 1'b0};
        vecs[11] = '{1'b0, 2'b01, 1'b1, 32'h0000_3001, 32'h0, 32'h8899_AABB, 0, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1};
        vecs[12] = '{1'b0, 2'b00, 1'b1, 32'h0000_7001, 32'h0, 32'h1240_7F00, 0, 32'h0000_7000, 4'b0100, 32'h0, 32'h0000_0040, 1'b0};

        rst_n = 1'b0; Start = 1'b0; IsWrite = 1'b0; Size = 2'b00; SignExt = 1'b0;
        Address = '0; StoreData = '0; mem_readdata = '0; mem_waitrequest = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_ctrl", {28'd0, Done, Busy, AddrError, mem_read}, 32'd0);
        chk("reset_write", {31'd0, mem_write}, 32'd0);
        chk("reset_load_data", LoadData, 32'd0);
        chk("reset_address", mem_address, 32'd0);
        chk("reset_be", {28'd0, mem_byteenable}, 32'd0);
        chk("reset_wdata", mem_writedata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 13; i++) run_txn(vecs[i], i);

        // Misaligned word: trapped on the aligned instance, performed as an
        // aligned word read on the CHECK_ALIGN=0 instance.
        begin
            int   d0_cyc, d1_cyc;
            logic d0_ae, d1_ae, d0_req;
            logic [31:0] d0_ld, d1_ld, d1_addr;
            d0_cyc = -1; d1_cyc = -1; d0_ae = 0; d1_ae = 1; d0_req = 0;
            d0_ld = 32'hFFFF_FFFF; d1_ld = '0; d1_addr = 32'hFFFF_FFFF;
            @(negedge clk);
            IsWrite = 1'b0; Size = 2'b10; SignExt = 1'b0; Address = 32'h0000_A002;
            mem_readdata = 32'hCAFE_F00D; mem_waitrequest = 1'b0; Start = 1'b1;
            for (int c = 1; c <= 4; c++) begin
                @(negedge clk);
                Start = 1'b0;
                if (mem_read || mem_write) d0_req = 1'b1;
                if (Done && d0_cyc < 0) begin d0_cyc = c; d0_ae = AddrError; d0_ld = LoadData; end
                if (u1_mem_read) d1_addr = u1_mem_address;
                if (u1_Done && d1_cyc < 0) begin d1_cyc = c; d1_ae = u1_AddrError; d1_ld = u1_LoadData; end
            end
            chk("misalign_done_cycle", 32'(d0_cyc), 32'd1);
            chk("misalign_addr_error", {31'd0, d0_ae}, 32'd1);
            chk("misalign_load_zero", d0_ld, 32'd0);
            chk("misalign_no_bus", {31'd0, d0_req}, 32'd0);
            chk("noalign_done_cycle", 32'(d1_cyc), 32'd2);
            chk("noalign_addr_error", {31'd0, d1_ae}, 32'd0);
            chk("noalign_address", d1_addr, 32'h0000_A000);
            chk("noalign_load", d1_ld, 32'hCAFE_F00D);
            $display("txn misalign: d0_done=%0d aerr=%0b d1_done=%0d d1_load=0x%08h",
                     d0_cyc, d0_ae, d1_cyc, d1_ld);
        end

        // Reset in the middle of a stalled ACCESS.
        begin
            logic done_seen;
            done_seen = 1'b0;
            @(negedge clk);
            IsWrite = 1'b0; Size = 2'b10; Address = 32'h0000_8000;
            mem_waitrequest = 1'b1; Start = 1'b1;
            @(negedge clk);
            Start = 1'b0;
            chk("rst_mid_read_before", {31'd0, mem_read}, 32'd1);
            rst_n = 1'b0;
            @(negedge clk);
            chk("rst_mid_read_after", {31'd0, mem_read}, 32'd0);
            chk("rst_mid_busy_done", {30'd0, Busy, Done}, 32'd0);
            rst_n = 1'b1;
            mem_waitrequest = 1'b0;
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                if (Done) done_seen = 1'b1;
            end
            chk("rst_mid_no_done", {31'd0, done_seen}, 32'd0);
            $display("txn reset_mid_access: done_seen=%0b", done_seen);
        end
        run_txn(vecs[8], 13);

        // Start pulses while busy are ignored.
        begin
            int   wr_cyc, done_cnt;
            logic addr_bad;
            wr_cyc = 0; done_cnt = 0; addr_bad = 0;
            @(negedge clk);
            IsWrite = 1'b1; Size = 2'b10; Address = 32'h0000_9000;
            StoreData = 32'h1111_2222; mem_waitrequest = 1'b0; Start = 1'b1;
            for (int c = 1; c <= 10; c++) begin
                @(negedge clk);
                Start = (c == 1 || c == 2);
                Address = 32'h0000_9100;
                mem_waitrequest = (c <= 2);
                if (mem_write) begin
                    wr_cyc++;
                    if (mem_address !== 32'h0000_9000) addr_bad = 1'b1;
                end
                if (Done) done_cnt++;
            end
            Start = 1'b0;
            chk("busy_start_write_cycles", 32'(wr_cyc), 32'd3);
            chk("busy_start_done_count", 32'(done_cnt), 32'd1);
            chk("busy_start_addr_stable", {31'd0, addr_bad}, 32'd0);
            $display("txn start_while_busy: write_cycles=%0d done_pulses=%0d", wr_cyc, done_cnt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
